// File: rtl/alu_pkg.sv
// Shared types and constants for the 6-bit signed ALU and its command queue.
package alu_pkg;
  localparam int ALU_W = 6;

  localparam logic [1:0] MODE_SHIFTADD = 2'b00;
  localparam logic [1:0] MODE_ADDMUL   = 2'b01;
  localparam logic [1:0] MODE_NEG      = 2'b10;
  localparam logic [1:0] MODE_ABS      = 2'b11;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [1:0]       mode;
  } alu_cmd_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_cmd_queue: circular storage with wrapping pointers and an occupancy count.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  alu_cmd_t                 wr_cmd,
  output alu_cmd_t                 rd_cmd,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  alu_cmd_t      mem_q [DEPTH];
  alu_cmd_t      mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_cmd;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries below count_q are ever popped.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_cmd = mem_q[rd_ptr_q];
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign count  = count_q;
endmodule

// File: rtl/alu_cmd_queue.sv
// Command queue and one-entry response register around the 6-bit ALU.
// Optional macro ALU_CMD_QUEUE_STATS_EN adds a 16-bit wrapping op_count of pops.
//   state     | meaning
//   RSP_EMPTY | response register holds nothing, rsp_valid=0
//   RSP_FULL  | response register holds a captured result, rsp_valid=1
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [W-1:0]           cmd_a,
  input  logic [W-1:0]           cmd_b,
  input  logic [1:0]             cmd_mode,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [1:0]             alu_mode,
  input  logic [W-1:0]           alu_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [W-1:0]           rsp_data,
  output logic [1:0]             rsp_mode,
  output logic [$clog2(DEPTH):0] q_count
`ifdef ALU_CMD_QUEUE_STATS_EN
  ,output logic [15:0]           op_count
`endif
);
  rsp_state_e state_q, state_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]   rsp_mode_q, rsp_mode_d;
  logic         push, pop, fifo_full, fifo_empty;
  alu_cmd_t     wr_cmd, head;

  assign wr_cmd = '{a: cmd_a, b: cmd_b, mode: cmd_mode};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_cmd (wr_cmd),
    .rd_cmd (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (q_count)
  );

  // cmd_ready comes from registered occupancy only, so a full queue stays closed even while popping.
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign rsp_valid = (state_q == RSP_FULL);
  assign pop       = !fifo_empty && (!rsp_valid || rsp_ready);

  assign alu_a    = head.a;
  assign alu_b    = head.b;
  assign alu_mode = head.mode;

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_mode_d = rsp_mode_q;
    if (pop) begin
      rsp_data_d = alu_out;
      rsp_mode_d = head.mode;
    end
    case (state_q)
      RSP_EMPTY: if (pop) state_d = RSP_FULL;
      RSP_FULL:  if (rsp_ready && !pop) state_d = RSP_EMPTY;
      default:   state_d = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RSP_EMPTY;
      rsp_data_q <= '0;
      rsp_mode_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_mode_q <= rsp_mode_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_mode = rsp_mode_q;

`ifdef ALU_CMD_QUEUE_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (pop) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue with a behavioural ALU and a queue-based reference model.
module tb_alu_cmd_queue;
  localparam int DEPTH = 4;
  localparam int W     = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [W-1:0] cmd_a, cmd_b;
  logic [1:0]   cmd_mode;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [1:0]   alu_mode;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_mode;
  logic [2:0]   q_count;
`ifdef ALU_CMD_QUEUE_STATS_EN
  logic [15:0]  op_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_cmd_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_mode  (cmd_mode),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_mode  (alu_mode),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_mode  (rsp_mode),
    .q_count   (q_count)
`ifdef ALU_CMD_QUEUE_STATS_EN
    ,.op_count (op_count)
`endif
  );

  // Signed arithmetic evaluated wide, then truncated to the 6-bit result.
  function automatic logic [5:0] alu_fn(input logic signed [5:0] a, input logic signed [5:0] b,
                                        input logic [1:0] m);
    int ia, ib, r;
    ia = a;
    ib = b;
    case (m)
      2'b00:   r = 2 * (ia + ib);
      2'b01:   r = ia + 3 * ib;
      2'b10:   r = -ib;
      default: begin
        r = 2 * ia - ib;
        if (r < 0) r = -r;
      end
    endcase
    return 6'(r);
  endfunction

  always_comb alu_out = alu_fn(alu_a, alu_b, alu_mode);

  // Reference model: pending results in issue order plus the held response slot ({mode, data}).
  logic [7:0] mq[$];
  logic       hv;
  logic [7:0] hd;
  int         pops;

  function automatic void model_clear();
    mq.delete();
    hv   = 1'b0;
    hd   = 8'h00;
    pops = 0;
  endfunction

  function automatic void model_step(input logic cv, input logic [5:0] a, input logic [5:0] b,
                                     input logic [1:0] m, input logic rr);
    logic do_pop, do_push;
    do_pop  = (mq.size() != 0) && (!hv || rr);
    do_push = cv && (mq.size() != DEPTH);
    if (do_pop) begin
      hd = mq.pop_front();
      hv = 1'b1;
      pops++;
    end else if (hv && rr) begin
      hv = 1'b0;
    end
    if (do_push) mq.push_back({m, alu_fn(a, b, m)});
  endfunction

  task automatic drive(input logic cv, input logic [5:0] a, input logic [5:0] b,
                       input logic [1:0] m, input logic rr);
    cmd_valid = cv;
    cmd_a     = a;
    cmd_b     = b;
    cmd_mode  = m;
    rsp_ready = rr;
  endtask

  task automatic step();
    model_step(cmd_valid, cmd_a, cmd_b, cmd_mode, rsp_ready);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 6'd1, 6'd1, 2'b00, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 6'd0, 6'd0, 2'b00, 1'b0);
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_q_count: got %0d want 0", q_count); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (rsp_data !== 6'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %0h want 0", rsp_data); end
    n_cmp++; if (rsp_mode !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_mode: got %0d want 0", rsp_mode); end
`ifdef ALU_CMD_QUEUE_STATS_EN
    n_cmp++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
`endif
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 6'd3, 6'd4, 2'b00, 1'b1);
    step();
    drive(1'b0, 6'd0, 6'd0, 2'b00, 1'b1);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL single_q_count: got %0d want 1", q_count); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 6'd14) begin n_fail++; $display("FAIL single_data: got %0d want 14", rsp_data); end
    n_cmp++; if (rsp_mode !== 2'b00) begin n_fail++; $display("FAIL single_mode: got %0d want 0", rsp_mode); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ta[4], tb_[4], te[4];
    logic [1:0] tm[4];
    ta  = '{6'd2, 6'd0, 6'd1, 6'd3};
    tb_ = '{6'd5, 6'd7, 6'd5, 6'd4};
    tm  = '{2'b01, 2'b10, 2'b11, 2'b00};
    te  = '{6'd17, 6'b111001, 6'd3, 6'd14};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, ta[i], tb_[i], tm[i], 1'b1);
      else       drive(1'b0, 6'd0, 6'd0, 2'b00, 1'b1);
      if (i >= 2) begin
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i-2, rsp_valid); end
        n_cmp++; if (rsp_data !== te[i-2]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h want %0h", i-2, rsp_data, te[i-2]); end
        n_cmp++; if (rsp_mode !== tm[i-2]) begin n_fail++; $display("FAIL b2b_mode[%0d]: got %0d want %0d", i-2, rsp_mode, tm[i-2]); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] ba[5], bb[5], be[5];
    logic [1:0] bm[5];
    int idx;
    ba = '{6'd1, 6'd2, 6'd5, 6'd7, 6'b111101};
    bb = '{6'd1, 6'd3, 6'd6, 6'd1, 6'd2};
    bm = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    be = '{6'd4, 6'd11, 6'b111010, 6'd13, 6'b111110};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ba[i], bb[i], bm[i], 1'b0);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 6'd9, 6'd9, 2'b00, 1'b0);
      n_cmp++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL bp_q_count: got %0d want 4", q_count); end
      n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready: got %b want 0", cmd_ready); end
      n_cmp++; if (rsp_data !== be[0] || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %0h/%b want %0h/1", rsp_data, rsp_valid, be[0]); end
      step();
    end
    drive(1'b1, 6'd9, 6'd9, 2'b00, 1'b1);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_bypass: got %b want 0", cmd_ready); end
    step();
    idx = 1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      drive(1'b0, 6'd0, 6'd0, 2'b00, 1'b1);
      if (rsp_valid) begin
        n_cmp++; if (rsp_data !== be[idx]) begin n_fail++; $display("FAIL bp_drain[%0d]: got %0h want %0h", idx, rsp_data, be[idx]); end
        idx++;
      end
      step();
    end
    n_cmp++; if (idx != 5) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 5", idx); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 6'd10, 6'd10, 2'b01, 1'b1);
    step();
    drive(1'b0, 6'd0, 6'd0, 2'b00, 1'b1);
    step();
    n_cmp++; if (rsp_data !== 6'b101000) begin n_fail++; $display("FAIL wrap_data: got %0h want 28", rsp_data); end
    n_cmp++; if (rsp_mode !== 2'b01) begin n_fail++; $display("FAIL wrap_mode: got %0d want 1", rsp_mode); end
    step();
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'($urandom), 6'($urandom), 2'($urandom), 1'b0);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 6'($urandom), 6'($urandom), 2'($urandom), 1'b1);
      n_cmp++; if (q_count !== 3'd2) begin n_fail++; $display("FAIL simul_q_count[%0d]: got %0d want 2", i, q_count); end
      n_cmp++; if (rsp_valid !== 1'b1 || {rsp_mode, rsp_data} !== hd) begin
        n_fail++; $display("FAIL simul_rsp[%0d]: got %b/%0h want 1/%0h", i, rsp_valid, {rsp_mode, rsp_data}, hd);
      end
      step();
    end
    for (int c = 0; c < 10 && (hv || mq.size() != 0); c++) begin
      drive(1'b0, 6'd0, 6'd0, 2'b00, 1'b1);
      n_cmp++; if (rsp_valid !== hv || (hv && {rsp_mode, rsp_data} !== hd)) begin
        n_fail++; $display("FAIL simul_drain: got %b/%0h want %b/%0h", rsp_valid, {rsp_mode, rsp_data}, hv, hd);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'($urandom), 6'($urandom), 2'($urandom), 1'b0);
      step();
    end
    n_cmp++; if (q_count !== 3'd3 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %0d/%b want 3/1", q_count, rsp_valid); end
    rst = 1'b1;
    drive(1'b1, 6'd5, 6'd5, 2'b00, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 6'd0, 6'd0, 2'b00, 1'b0);
    model_clear();
    n_cmp++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL mid_q_count: got %0d want 0", q_count); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_cmd_ready: got %b want 1", cmd_ready); end
`ifdef ALU_CMD_QUEUE_STATS_EN
    n_cmp++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL mid_op_count: got %0d want 0", op_count); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom), 2'($urandom),
            ($urandom_range(0, 9) < 7));
      n_cmp++; if (cmd_ready !== (mq.size() != DEPTH)) begin n_fail++; $display("FAIL rnd_cmd_ready[%0d]: got %b want %b", i, cmd_ready, mq.size() != DEPTH); end
      n_cmp++; if (q_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_q_count[%0d]: got %0d want %0d", i, q_count, mq.size()); end
      n_cmp++; if (rsp_valid !== hv) begin n_fail++; $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", i, rsp_valid, hv); end
      if (hv) begin
        n_cmp++; if ({rsp_mode, rsp_data} !== hd) begin n_fail++; $display("FAIL rnd_rsp[%0d]: got %0h want %0h", i, {rsp_mode, rsp_data}, hd); end
      end
      step();
    end
    for (int c = 0; c < 10 && (hv || mq.size() != 0); c++) begin
      drive(1'b0, 6'd0, 6'd0, 2'b00, 1'b1);
      n_cmp++; if (rsp_valid !== hv || (hv && {rsp_mode, rsp_data} !== hd)) begin
        n_fail++; $display("FAIL rnd_drain: got %b/%0h want %b/%0h", rsp_valid, {rsp_mode, rsp_data}, hv, hd);
      end
      step();
    end
    n_cmp++; if (rsp_valid !== 1'b0 || q_count !== 3'd0) begin n_fail++; $display("FAIL rnd_idle: got %b/%0d want 0/0", rsp_valid, q_count); end
`ifdef ALU_CMD_QUEUE_STATS_EN
    n_cmp++; if (op_count !== 16'(pops)) begin n_fail++; $display("FAIL rnd_op_count: got %0d want %0d", op_count, pops); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 6'd0, 6'd0, 2'b00, 1'b0);
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_simul();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
